sipo_frame: RTL and testbench

SIPO_FRAME -- requirements
Module: sipo_frame

---
 rtl/sipo_pkg.sv | 19 +
 rtl/sipo_row_ctr.sv | 29 ++
 rtl/sipo_frame.sv | 112 +++++++++++
 tb/tb_sipo_frame.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared constants for the serial-to-parallel framer: row width, parameter limits, parity polarity.
// Latency: none (package only).
// Backpressure: not applicable.
`timescale 1ns/1ps
package sipo_pkg;

  localparam int ROW_W     = 4;
  localparam int MAX_WIDTH = 128;
  localparam int MAX_ROWS  = 15;

  // Even parity: XOR over data bits plus the parity bit must equal this value.
  localparam logic PARITY_EVEN = 1'b0;

  function automatic logic [ROW_W-1:0] row_next(input logic [ROW_W-1:0] cur,
                                                input logic [ROW_W-1:0] last);
    return (cur == last) ? ROW_W'(1) : cur + ROW_W'(1);
  endfunction

endpackage

// File: rtl/sipo_row_ctr.sv
// Row index 1..ROWS for the framer; clr forces 0 so the next word becomes row 1.
// Latency: row updates on the edge where adv or clr is sampled.
// Backpressure: none; advances only on words the framer actually loads.
`timescale 1ns/1ps
module sipo_row_ctr
  import sipo_pkg::*;
#(
  parameter int ROWS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [ROW_W-1:0] row
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS);

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
    end else if (clr) begin
      row <= '0;
    end else if (adv) begin
      row <= row_next(row, ROW_LAST);
    end
  end

endmodule

// File: rtl/sipo_frame.sv
// Serial-to-parallel word framer with row indexing; SIPO_FRAME_PARITY_EN adds a trailing even-parity bit.
// Latency: word appears on dout one cycle after the en cycle carrying its last bit.
// Backpressure: load/out_ready handshake; a word completing while one is held unaccepted is dropped and flags overrun.
`timescale 1ns/1ps
module sipo_frame
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 70,
  parameter int ROWS      = 12,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             sync,
  input  logic             out_ready,
  output logic             load,
  output logic [WIDTH-1:0] dout,
  output logic [ROW_W-1:0] row,
  output logic             overrun,
  output logic             perr
);

`ifdef SIPO_FRAME_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int LAST  = WIDTH - 1 + PAR_BITS;
  localparam int CNT_W = $clog2(LAST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] cnt;
  logic             data_bit;
  logic             word_done;
  logic             word_perr;
  logic             accept;
  logic             take;
  logic             drop;

  always_comb begin
    shift_nxt = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], din} : {din, sreg[WIDTH-1:1]};
    // sync restarts the count, so an en cycle under sync is always bit 0 and never completes a word.
    word_done = en && !sync && (cnt == CNT_LAST);
`ifdef SIPO_FRAME_PARITY_EN
    data_bit  = en && (sync || (cnt != CNT_LAST));
    word      = sreg;
    word_perr = ((^sreg) ^ din) != PARITY_EVEN;
`else
    data_bit  = en;
    word      = shift_nxt;
    word_perr = 1'b0;
`endif
    accept = load && out_ready;
    take   = word_done && (!load || out_ready);
    drop   = word_done && load && !out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (sync) begin
      cnt <= en ? CNT_W'(1) : '0;
    end else if (en) begin
      cnt <= word_done ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (data_bit) begin
      sreg <= shift_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load    <= 1'b0;
      dout    <= '0;
      perr    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (take) begin
        load <= 1'b1;
        dout <= word;
        perr <= word_perr;
      end else if (accept) begin
        load <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  sipo_row_ctr #(
    .ROWS(ROWS)
  ) u_row_ctr (
    .clk(clk),
    .rst(rst),
    .clr(sync),
    .adv(take),
    .row(row)
  );

endmodule

// File: tb/tb_sipo_frame.sv
// Directed self-checking bench for sipo_frame: MSB-first instance (u0) and LSB-first instance (u1).
`timescale 1ns/1ps
module tb_sipo_frame;

`ifdef SIPO_FRAME_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, din, sync, out_ready;
  logic       load, overrun, perr;
  logic [7:0] dout;
  logic [3:0] row;

  logic       en1, din1, sync1, rdy1;
  logic       load1, ov1, perr1;
  logic [7:0] dout1;
  logic [3:0] row1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sipo_frame #(.WIDTH(8), .ROWS(3), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync), .out_ready(out_ready),
    .load(load), .dout(dout), .row(row), .overrun(overrun), .perr(perr)
  );

  sipo_frame #(.WIDTH(8), .ROWS(3), .MSB_FIRST(0)) u1 (
    .clk(clk), .rst(rst), .en(en1), .din(din1), .sync(sync1), .out_ready(rdy1),
    .load(load1), .dout(dout1), .row(row1), .overrun(ov1), .perr(perr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // MSB-first word into u0 (plus even parity when enabled); out_ready is rdy_bits except rdy_last on the final bit.
  task automatic send0(input logic [7:0] w, input logic rdy_bits, input logic rdy_last,
                       input bit hold_chk, input bit sync_first);
    int nb;
    nb = 8 + PB;
    for (int i = 0; i < nb; i++) begin
      en        = 1'b1;
      din       = (i < 8) ? w[7-i] : ^w;
      sync      = sync_first && (i == 0);
      out_ready = (i == nb - 1) ? rdy_last : rdy_bits;
      step();
      if (hold_chk && i < nb - 1) chk("hold_load", load, 1);
    end
    en   = 1'b0;
    sync = 1'b0;
  endtask

  task automatic send1(input logic [7:0] w, input logic p);
    for (int i = 0; i < 8 + PB; i++) begin
      en1  = 1'b1;
      din1 = (i < 8) ? w[i] : p;
      step();
    end
    en1 = 1'b0;
  endtask

  logic [7:0] words [4];
  logic [3:0] rows  [4];

  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0; sync = 1'b0; out_ready = 1'b0;
    en1 = 1'b0; din1 = 1'b0; sync1 = 1'b0; rdy1 = 1'b1;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    rows[0]  = 4'd1;  rows[1]  = 4'd2;  rows[2]  = 4'd3;  rows[3]  = 4'd1;
    step();
    step();
    rst = 1'b0;
    chk("rst_load", load, 0);
    chk("rst_dout", dout, 0);
    chk("rst_row", row, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_perr", perr, 0);

    // First word, accepted immediately
    send0(8'hB2, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("w1_dout", dout, 8'hB2);
    chk("w1_row", row, 1);
    chk("w1_load", load, 1);
    chk("w1_perr", perr, 0);
    step();
    chk("w1_load_drop", load, 0);

    // Back-to-back words, each accepted on the cycle the next completes
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("b2b_row_clr", row, 0);
    for (int k = 0; k < 4; k++) begin
      send0(words[k], 1'b0, (k > 0), (k > 0), 1'b0);
      chk("b2b_dout", dout, words[k]);
      chk("b2b_row", row, rows[k]);
      chk("b2b_load", load, 1);
      chk("b2b_overrun", overrun, 0);
    end
    out_ready = 1'b1;
    step();
    chk("b2b_load_drop", load, 0);

    // Overrun: second word dropped while first is held
    out_ready = 1'b0;
    send0(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_dout1", dout, 8'hAA);
    chk("ovr_row1", row, 2);
    chk("ovr_flag0", overrun, 0);
    send0(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_dout2", dout, 8'hAA);
    chk("ovr_row2", row, 2);
    chk("ovr_flag1", overrun, 1);
    chk("ovr_load", load, 1);
    out_ready = 1'b1;
    step();
    chk("ovr_load_drop", load, 0);
    chk("ovr_sticky", overrun, 1);

    // Sync mid-word discards the partial bits
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; din = 1'b1;
      step();
    end
    en = 1'b0;
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_row0", row, 0);
    send0(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sync_dout", dout, 8'h0F);
    chk("sync_row1", row, 1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_pend_load", load, 1);
    chk("sync_pend_dout", dout, 8'h0F);
    chk("sync_pend_row", row, 0);
    out_ready = 1'b1;
    step();
    chk("sync_pend_drop", load, 0);
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; din = 1'b0;
      step();
    end
    send0(8'h96, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("syncen_dout", dout, 8'h96);
    chk("syncen_row", row, 1);

    // Reset mid-word, with en still high during reset
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; din = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    en  = 1'b0;
    chk("mrst_load", load, 0);
    chk("mrst_dout", dout, 0);
    chk("mrst_row", row, 0);
    chk("mrst_overrun", overrun, 0);
    chk("mrst_perr", perr, 0);
    send0(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mrst_w_dout", dout, 8'h5A);
    chk("mrst_w_row", row, 1);
    chk("mrst_w_overrun", overrun, 0);

    // LSB-first instance, parity polarity when enabled
    chk("lsb_rst_dout", dout1, 0);
    send1(8'h03, 1'b1);
    chk("lsb_dout_a", dout1, 8'h03);
    chk("lsb_perr_a", perr1, (PB != 0) ? 1 : 0);
    chk("lsb_row_a", row1, 1);
    send1(8'h03, 1'b0);
    chk("lsb_dout_b", dout1, 8'h03);
    chk("lsb_perr_b", perr1, 0);
    send1(8'h80, 1'b0);
    chk("lsb_dout_c", dout1, 8'h80);
    chk("lsb_perr_c", perr1, (PB != 0) ? 1 : 0);
    chk("lsb_row_c", row1, 3);
    chk("lsb_load", load1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
